regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_pick.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 81 ++++++++
 tb/tb_regfile_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its writeback requesters.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 8;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_IO   = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      winner,
    output logic            any
);

    // Two passes avoid a computed index: ptr..NREQ-1 first, then 0..ptr-1.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                winner = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[i] && (i < int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                winner = 2'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port among writeback requesters,
// with a one-entry registered output stage driving A3/WriteData/regWriteEnable.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     regWriteEnable,
    output logic [1:0]               grant_id
);

    localparam logic [1:0] LAST = 2'(NREQ - 1);

    logic [1:0]        ptr;
    logic [1:0]        ptr_nxt;
    logic [1:0]        winner;
    logic [NREQ-1:0]   vld_masked;
    logic [NREQ-1:0]   gnt;
    logic              any;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign vld_masked = hold ? '0 : req_valid;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .valid  (vld_masked),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner),
        .any    (any)
    );

    assign req_ready = rst_n ? gnt : '0;
    assign accept    = any & rst_n;
    assign ptr_nxt   = (winner == LAST) ? 2'd0 : winner + 2'd1;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: loaded on acceptance; enable drops otherwise while address/data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= '0;
            A3             <= '0;
            WriteData      <= '0;
            regWriteEnable <= 1'b0;
            grant_id       <= '0;
        end else if (accept) begin
            ptr            <= ptr_nxt;
            A3             <= sel_addr;
            WriteData      <= sel_data;
            regWriteEnable <= 1'b1;
            grant_id       <= winner;
        end else begin
            regWriteEnable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register file model on the write port.
module tb_regfile_write_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   hold;
    logic [ADDR_W-1:0]      A3;
    logic [DATA_W-1:0]      WriteData;
    logic                   regWriteEnable;
    logic [1:0]             grant_id;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] rf [0:31];

    regfile_write_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .hold           (hold),
        .A3             (A3),
        .WriteData      (WriteData),
        .regWriteEnable (regWriteEnable),
        .grant_id       (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (regWriteEnable) rf[A3] <= WriteData;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        req_valid = 3'b111;
        set_req(0, 5'd7, 8'd70);
        set_req(1, 5'd8, 8'd80);
        set_req(2, 5'd9, 8'd90);
        step();
        step();
        checks++; if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_rwe got=%0b exp=0", regWriteEnable); end
        checks++; if (A3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
        checks++; if (WriteData !== 8'd0) begin errors++; $display("FAIL reset_wd got=%0d exp=0", WriteData); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_ready got=%b exp=001", req_ready); end
        step();
        checks++; if (regWriteEnable !== 1'b1 || A3 !== 5'd7 || grant_id !== 2'd0) begin
            errors++; $display("FAIL reset_first_write got rwe=%0b a3=%0d gid=%0d exp rwe=1 a3=7 gid=0", regWriteEnable, A3, grant_id);
        end
        // ptr is now 1; a mid-stream reset must drop the write and clear ptr
        rst_n = 1'b0;
        #1;
        checks++; if (regWriteEnable !== 1'b0 || A3 !== 5'd0 || WriteData !== 8'd0) begin
            errors++; $display("FAIL reset_async got rwe=%0b a3=%0d wd=%0d exp 0/0/0", regWriteEnable, A3, WriteData);
        end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_async_ready got=%b exp=000", req_ready); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_ptr_cleared got=%b exp=001", req_ready); end
        req_valid = 3'b000;
        step();
        checks++; if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_idle_rwe got=%0b exp=0", regWriteEnable); end
    endtask

    task automatic test_single();
        // ptr = 0 here
        req_valid = 3'b010;
        set_req(1, 5'd2, 8'd42);
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
        step();
        req_valid = 3'b000;
        checks++; if (regWriteEnable !== 1'b1 || A3 !== 5'd2 || WriteData !== 8'd42 || grant_id !== 2'd1) begin
            errors++; $display("FAIL single_port got rwe=%0b a3=%0d wd=%0d gid=%0d exp 1/2/42/1", regWriteEnable, A3, WriteData, grant_id);
        end
        step();
        checks++; if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL single_rwe_drop got=%0b exp=0", regWriteEnable); end
        checks++; if (rf[2] !== 8'd42) begin errors++; $display("FAIL single_readback got=%0d exp=42", rf[2]); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gid [4];
        logic [4:0] exp_a3  [4];
        exp_gid = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_a3  = '{5'd1, 5'd2, 5'd3, 5'd1};
        // ptr = 2 after the single write; one grant to req2 returns it to 0
        req_valid = 3'b100;
        set_req(2, 5'd10, 8'd5);
        step();
        req_valid = 3'b111;
        set_req(0, 5'd1, 8'd11);
        set_req(1, 5'd2, 8'd22);
        set_req(2, 5'd3, 8'd33);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (regWriteEnable !== 1'b1 || grant_id !== exp_gid[k] || A3 !== exp_a3[k]) begin
                errors++; $display("FAIL contention_%0d got rwe=%0b gid=%0d a3=%0d exp rwe=1 gid=%0d a3=%0d",
                                   k, regWriteEnable, grant_id, A3, exp_gid[k], exp_a3[k]);
            end
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_same_addr();
        // ptr = 1; a lone req2 grant brings it to 0
        req_valid = 3'b100;
        set_req(2, 5'd11, 8'd6);
        step();
        req_valid = 3'b101;
        set_req(0, 5'd4, 8'd99);
        set_req(2, 5'd4, 8'd67);
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL same_first_ready got=%b exp=001", req_ready); end
        step();
        req_valid = 3'b100;
        checks++; if (grant_id !== 2'd0 || WriteData !== 8'd99) begin
            errors++; $display("FAIL same_first got gid=%0d wd=%0d exp 0/99", grant_id, WriteData);
        end
        step();
        req_valid = 3'b000;
        checks++; if (grant_id !== 2'd2 || WriteData !== 8'd67 || regWriteEnable !== 1'b1) begin
            errors++; $display("FAIL same_second got gid=%0d wd=%0d rwe=%0b exp 2/67/1", grant_id, WriteData, regWriteEnable);
        end
        step();
        checks++; if (rf[4] !== 8'd67) begin errors++; $display("FAIL same_final got=%0d exp=67", rf[4]); end
    endtask

    task automatic test_hold();
        // ptr = 0; grant req0 so ptr becomes 1 with a write in the output stage
        req_valid = 3'b011;
        set_req(0, 5'd12, 8'd120);
        set_req(1, 5'd13, 8'd130);
        step();
        hold = 1'b1;
        checks++; if (regWriteEnable !== 1'b1 || grant_id !== 2'd0) begin
            errors++; $display("FAIL hold_inflight got rwe=%0b gid=%0d exp 1/0", regWriteEnable, grant_id);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready_%0d got=%b exp=000", k, req_ready); end
            step();
            checks++; if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL hold_rwe_%0d got=%0b exp=0", k, regWriteEnable); end
        end
        hold = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL hold_release_ready got=%b exp=010", req_ready); end
        step();
        req_valid = 3'b000;
        checks++; if (regWriteEnable !== 1'b1 || grant_id !== 2'd1 || A3 !== 5'd13) begin
            errors++; $display("FAIL hold_release got rwe=%0b gid=%0d a3=%0d exp 1/1/13", regWriteEnable, grant_id, A3);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (regWriteEnable !== 1'b0 || A3 !== 5'd13 || WriteData !== 8'd130) begin
                errors++; $display("FAIL idle_%0d got rwe=%0b a3=%0d wd=%0d exp 0/13/130", k, regWriteEnable, A3, WriteData);
            end
        end
    endtask

    task automatic test_addr_edges();
        // ptr = 2; req2 to address 31, then req0 to address 0, back to back
        req_valid = 3'b101;
        set_req(2, 5'd31, 8'hFF);
        set_req(0, 5'd0, 8'h5A);
        step();
        req_valid = 3'b001;
        checks++; if (A3 !== 5'd31 || WriteData !== 8'hFF || grant_id !== 2'd2) begin
            errors++; $display("FAIL edge_top got a3=%0d wd=%0h gid=%0d exp 31/ff/2", A3, WriteData, grant_id);
        end
        step();
        req_valid = 3'b000;
        checks++; if (A3 !== 5'd0 || WriteData !== 8'h5A || regWriteEnable !== 1'b1) begin
            errors++; $display("FAIL edge_zero got a3=%0d wd=%0h rwe=%0b exp 0/5a/1", A3, WriteData, regWriteEnable);
        end
        step();
        checks++; if (rf[31] !== 8'hFF || rf[0] !== 8'h5A) begin
            errors++; $display("FAIL edge_rf got r31=%0h r0=%0h exp ff/5a", rf[31], rf[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hold = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_same_addr();
        test_hold();
        test_idle();
        test_addr_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
